// File: rtl/foobar_event_fifo.sv
// Timestamped event FIFO: FOO/BAR pulses qualified by en are stamped and queued
// first-word-fall-through. Events arriving while full are dropped and counted.
module foobar_event_fifo #(
  parameter int DEPTH = 8,
  parameter int TS_W  = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clr,
  input  logic                     en,
  input  logic                     foo,
  input  logic                     bar,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [1:0]               out_code,
  output logic [TS_W-1:0]          out_ts,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     overflow,
  output logic [7:0]               drop_count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LEVEL = (AW+1)'(DEPTH);

  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [TS_W-1:0] ts;
  logic [1:0]      code_mem [DEPTH];
  logic [TS_W-1:0] ts_mem   [DEPTH];

  logic evt;
  logic full;
  logic push;
  logic pop;
  logic drop;

  always_comb begin
    evt  = en & (foo | bar);
    full = (level == FULL_LEVEL);
    pop  = out_valid & out_ready;
    push = evt & (~full | pop);
    drop = evt & full & ~pop;
  end

  assign out_valid = (level != '0);
  // Outputs are forced to zero when empty so the unreset storage never leaks out.
  assign out_code  = out_valid ? code_mem[rd_ptr] : 2'b00;
  assign out_ts    = out_valid ? ts_mem[rd_ptr]   : '0;

  // NOTE: storage has no reset; validity is tracked by level, so clearing the
  // array would only cost reset fan-out.
  always_ff @(posedge clk) begin
    if (push && !clr) begin
      code_mem[wr_ptr] <= {bar, foo};
      ts_mem[wr_ptr]   <= ts;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ts         <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      level      <= '0;
      overflow   <= 1'b0;
      drop_count <= 8'd0;
    end else if (clr) begin
      ts         <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      level      <= '0;
      overflow   <= 1'b0;
      drop_count <= 8'd0;
    end else begin
      if (en)   ts     <= ts + TS_W'(1);
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      if (push && !pop)      level <= level + (AW+1)'(1);
      else if (pop && !push) level <= level - (AW+1)'(1);
      if (drop) begin
        overflow <= 1'b1;
        if (drop_count != 8'd255) drop_count <= drop_count + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_foobar_event_fifo.sv
// Self-checking bench for foobar_event_fifo: reference queue model acts as the
// scoreboard, plus table-driven and hand-written corner-case sequences.
module tb_foobar_event_fifo;

  localparam int DEPTH = 8;
  localparam int TS_W  = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       clr = 1'b0;
  logic       en = 1'b0;
  logic       foo = 1'b0;
  logic       bar = 1'b0;
  logic       out_ready = 1'b0;
  logic       out_valid;
  logic [1:0] out_code;
  logic [TS_W-1:0] out_ts;
  logic [$clog2(DEPTH):0] level;
  logic       overflow;
  logic [7:0] drop_count;

  foobar_event_fifo #(.DEPTH(DEPTH), .TS_W(TS_W)) dut (
    .clk(clk), .rst_n(rst_n), .clr(clr), .en(en), .foo(foo), .bar(bar),
    .out_valid(out_valid), .out_ready(out_ready), .out_code(out_code),
    .out_ts(out_ts), .level(level), .overflow(overflow), .drop_count(drop_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0]      code;
    logic [TS_W-1:0] ts;
  } ent_t;

  typedef struct {
    bit en;
    bit foo;
    bit bar;
    bit rdy;
    int exp_level;
  } vec_t;

  ent_t       mq[$];
  logic [9:0] obs[$];
  logic [TS_W-1:0] m_ts;
  logic       m_ovf;
  int         m_drop;
  int         checks = 0;
  int         errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    mq.delete();
    m_ts   = '0;
    m_ovf  = 1'b0;
    m_drop = 0;
  endtask

  // Entered just after a posedge; drives one cycle and scores it.
  task automatic step(input bit e, input bit f, input bit b, input bit r, input bit c);
    bit pop;
    en = e; foo = f; bar = b; out_ready = r; clr = c;
    @(negedge clk);
    check("valid", out_valid, 32'(mq.size() != 0));
    pop = !c && (mq.size() != 0) && r;
    if (pop) begin
      check("head_code", out_code, mq[0].code);
      check("head_ts", out_ts, mq[0].ts);
      obs.push_back({out_code, out_ts});
    end
    if (c) model_clear();
    else begin
      if (pop) void'(mq.pop_front());
      if (e && (f || b)) begin
        if (mq.size() < DEPTH) mq.push_back({b, f, m_ts});
        else begin
          m_ovf = 1'b1;
          if (m_drop != 255) m_drop++;
        end
      end
      if (e) m_ts = m_ts + 1'b1;
    end
    @(posedge clk);
    #1;
    check("level", level, mq.size());
    check("overflow", overflow, m_ovf);
    check("drop_count", drop_count, m_drop);
  endtask

  task automatic do_reset();
    en = 0; foo = 0; bar = 0; out_ready = 0; clr = 0;
    rst_n = 1'b0;
    #2;
    check("rst_valid", out_valid, 0);
    check("rst_level", level, 0);
    check("rst_code", out_code, 0);
    check("rst_ts", out_ts, 0);
    check("rst_overflow", overflow, 0);
    check("rst_drop", drop_count, 0);
    model_clear();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    obs.delete();
  endtask

  logic [9:0] exp36 [8];
  vec_t tab [5];

  initial begin
    exp36 = '{10'h300, 10'h103, 10'h205, 10'h106, 10'h109, 10'h20A, 10'h10C, 10'h30F};
    tab[0] = '{en: 1, foo: 1, bar: 0, rdy: 0, exp_level: 1};
    tab[1] = '{en: 0, foo: 1, bar: 0, rdy: 0, exp_level: 1};
    tab[2] = '{en: 1, foo: 1, bar: 0, rdy: 0, exp_level: 2};
    tab[3] = '{en: 0, foo: 0, bar: 0, rdy: 1, exp_level: 1};
    tab[4] = '{en: 0, foo: 0, bar: 0, rdy: 1, exp_level: 0};

    // Mixed FOO/BAR stream with consumer always ready.
    do_reset();
    for (int i = 0; i < 16; i++) step(1, (i % 3) == 0, (i % 5) == 0, 1, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 1, 0);
    check("seq_count", obs.size(), 8);
    for (int i = 0; i < 8 && i < obs.size(); i++) check("seq_entry", obs[i], exp36[i]);
    check("seq_overflow", overflow, 0);

    // Overflow with stalled consumer, then drain.
    do_reset();
    for (int i = 0; i < 10; i++) step(1, 1, 0, 0, 0);
    check("ovf_level", level, 8);
    check("ovf_flag", overflow, 1);
    check("ovf_drops", drop_count, 2);
    for (int i = 0; i < 8; i++) step(0, 0, 0, 1, 0);
    for (int i = 0; i < 8 && i < obs.size(); i++) check("drain_ts", obs[i], {2'b01, 8'(i)});

    // Full FIFO with simultaneous pop and event.
    do_reset();
    for (int i = 0; i < 8; i++) step(1, 0, 1, 0, 0);
    step(1, 1, 1, 1, 0);
    check("fullpp_level", level, 8);
    check("fullpp_overflow", overflow, 0);
    for (int i = 0; i < 8; i++) step(0, 0, 0, 1, 0);
    check("fullpp_last", obs[obs.size()-1], 10'h308);

    // en gating: the en=0 cycle must not push.
    do_reset();
    foreach (tab[i]) begin
      step(tab[i].en, tab[i].foo, tab[i].bar, tab[i].rdy, 0);
      check("tab_level", level, tab[i].exp_level);
    end
    check("gate_count", obs.size(), 2);
    if (obs.size() == 2) begin
      check("gate_e0", obs[0], 10'h100);
      check("gate_e1", obs[1], 10'h101);
    end

    // Timestamp wrap.
    do_reset();
    for (int i = 0; i < 300; i++) step(1, i == 256, 0, 1, 0);
    check("wrap_count", obs.size(), 1);
    if (obs.size() == 1) check("wrap_ts", obs[0], 10'h100);

    // drop_count saturation.
    do_reset();
    for (int i = 0; i < 270; i++) step(1, 1, 0, 0, 0);
    check("sat_drops", drop_count, 255);
    check("sat_overflow", overflow, 1);

    // Asynchronous reset mid-cycle with 5 entries buffered.
    do_reset();
    for (int i = 0; i < 5; i++) step(1, 1, 0, 0, 0);
    check("pre_arst_level", level, 5);
    en = 0; foo = 0;
    #3;
    rst_n = 1'b0;
    #1;
    check("arst_valid", out_valid, 0);
    check("arst_level", level, 0);
    check("arst_code", out_code, 0);
    #1;
    rst_n = 1'b1;
    model_clear();
    @(posedge clk);
    #1;
    step(1, 0, 1, 0, 0);
    step(0, 0, 0, 1, 0);
    check("post_arst_entry", obs[obs.size()-1], 10'h200);

    // clr with a concurrent event.
    do_reset();
    for (int i = 0; i < 3; i++) step(1, 1, 0, 0, 0);
    step(1, 1, 1, 1, 1);
    check("clr_level", level, 0);
    check("clr_valid", out_valid, 0);
    step(0, 0, 0, 1, 0);
    step(1, 1, 0, 0, 0);
    step(0, 0, 0, 1, 0);
    check("post_clr_entry", obs[obs.size()-1], 10'h100);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/foobar_event_fifo.md
FOOBAR_EVENT_FIFO -- requirements
Module: foobar_event_fifo

Interface
REQ-001 The block SHALL have parameter DEPTH, default 8, meaning FIFO entry count (power of two, 2..64).
REQ-002 The block SHALL have parameter TS_W, default 8, meaning timestamp width in bits.
REQ-003 The block SHALL have port clk, input, 1, single clock; all state updates on posedge clk.
REQ-004 The block SHALL have port rst_n, input, 1, reset; asynchronous, active-low.
REQ-005 The block SHALL have port clr, input, 1, synchronous clear of all state.
REQ-006 The block SHALL have port en, input, 1, upstream enable; qualifies foo/bar and advances the timestamp.
REQ-007 The block SHALL have port foo, input, 1, upstream FOO pulse.
REQ-008 The block SHALL have port bar, input, 1, upstream BAR pulse.
REQ-009 The block SHALL have port out_valid, output, 1, head entry available.
REQ-010 The block SHALL have port out_ready, input, 1, consumer accepts the head entry.
REQ-011 The block SHALL have port out_code, output, 2, head event code: 01 FOO, 10 BAR, 11 FOOBAR.
REQ-012 The block SHALL have port out_ts, output, TS_W, head event timestamp.
REQ-013 The block SHALL have port level, output, $clog2(DEPTH)+1, current occupancy.
REQ-014 The block SHALL have port overflow, output, 1, sticky flag set on any dropped event.
REQ-015 The block SHALL have port drop_count, output, 8, saturating count of dropped events.

Function
REQ-016 The timestamp counter (TS_W bits) SHALL increment by 1 on every cycle with en=1 and wrap from 2^TS_W-1 to 0.
REQ-017 An event SHALL occur on a cycle with en=1 and (foo|bar)=1, with code {bar,foo}; foo/bar SHALL be ignored when en=0.
REQ-018 The timestamp recorded with an event SHALL be the counter value before that cycle's increment.
REQ-019 A push SHALL occur on an event when the FIFO is not full, or when it is full and a pop occurs in the same cycle.
REQ-020 A pop SHALL occur when out_valid=1 and out_ready=1.
REQ-021 The FIFO SHALL be first-word-fall-through: out_code/out_ts SHALL show the head entry whenever out_valid=1, with no extra read latency.
REQ-022 An event pushed at edge n into an empty FIFO SHALL give out_valid=1 in the cycle after edge n (one-cycle latency).
REQ-023 out_code/out_ts SHALL hold stable while out_valid=1 and out_ready=0.
REQ-024 level SHALL be +1 on push-only, -1 on pop-only, and unchanged on push+pop or idle.
REQ-025 out_valid SHALL equal (level != 0).
REQ-026 Simultaneous push and pop on an empty FIFO SHALL NOT occur, because out_valid=0; the event is pushed and level becomes 1.
REQ-027 An event while full with no pop SHALL be dropped: FIFO unchanged, overflow set to 1, drop_count incremented.
REQ-028 drop_count SHALL saturate at 255.
REQ-029 overflow SHALL stay 1 until rst_n or clr.
REQ-030 Read/write pointers SHALL wrap modulo DEPTH.
REQ-031 clr=1 SHALL have priority over push/pop in that cycle and SHALL return the block to reset values at the next edge.

Reset
REQ-032 While rst_n=0, the block SHALL immediately (without a clock) force timestamp=0, pointers=0, level=0, out_valid=0, out_code=00, out_ts=0, overflow=0, drop_count=0.
REQ-033 Reset asserted mid-operation SHALL discard all buffered entries.
REQ-034 After rst_n deasserts, the first event SHALL carry timestamp 0 if it occurs on the first en=1 cycle.
REQ-035 rst_n deassertion SHALL be synchronised externally; no internal synchroniser is required.

Verification
REQ-036 Reset, then en=1 for 16 cycles with foo at counts 0,3,6,9,12,15 and bar at 0,5,10,15, out_ready=1 -> output sequence (11,0),(01,3),(10,5),(01,6),(01,9),(10,10),(01,12),(11,15), overflow=0.
REQ-037 out_ready=0, 10 events on consecutive en cycles with DEPTH=8 -> level=8, overflow=1, drop_count=2; draining yields timestamps 0..7 in order.
REQ-038 FIFO full with out_ready=1 and an event in the same cycle -> event accepted, level stays 8, overflow stays 0.
REQ-039 en toggled 1,0,1 with foo=1 on all three cycles -> two entries with timestamps 0 and 1; the en=0 cycle pushes nothing.
REQ-040 Timestamp wrap: 300 en cycles with an event at cycle 256 -> recorded out_ts=0.
REQ-041 rst_n pulsed low asynchronously between edges with level=5 -> out_valid=0 and level=0 before the next edge; clr=1 with a concurrent event -> level=0 at the next edge and the event is not stored.
